// File: rtl/qspi_serializer_if.sv
// ---------------------------------------------------------------------------
// qspi_serializer_if
// Purpose : groups the word-ingress handshake and the nibble-egress pins of
//           qspi_serializer into one bundle.
// Signals :
//   word_data/word_valid -> word offered by the collector
//   word_ready           <- FIFO can accept (not full)
//   qspi_data            <- current nibble, 4'h0 outside a frame
//   qspi_sending         <- high while a frame nibble is on qspi_data
//   qspi_ready           -> far end can accept a new frame
//   fifo_count           <- words held in the FIFO
//   busy                 <- frame in flight or FIFO not empty
// Modports: master = collector/far-end side, slave = serializer side.
// ---------------------------------------------------------------------------
interface qspi_serializer_if #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_valid;
    logic                  word_ready;
    logic [3:0]            qspi_data;
    logic                  qspi_sending;
    logic                  qspi_ready;
    logic [CNT_W-1:0]      fifo_count;
    logic                  busy;

    modport master (
        output word_data, word_valid, qspi_ready,
        input  word_ready, qspi_data, qspi_sending, fifo_count, busy
    );

    modport slave (
        input  word_data, word_valid, qspi_ready,
        output word_ready, qspi_data, qspi_sending, fifo_count, busy
    );
endinterface

// File: rtl/qspi_serializer.sv
// ---------------------------------------------------------------------------
// qspi_serializer
// Purpose : output end of the QSPI nibble link. Parallel words are queued in a
//           small FIFO and sent MSB nibble first as frames on qspi_data while
//           qspi_sending is high. Frames are separated by at least one idle
//           cycle; a new frame only starts when qspi_ready is high in IDLE.
// Ports   :
//   clk    - single clock, all state on the rising edge
//   reset  - asynchronous, active-low; clears FIFO, FSM and outputs
//   bus    - qspi_serializer_if.slave (handshake, nibble pins, status)
// Options :
//   QSPI_PARITY_EN - when defined, each frame gets one extra trailing nibble
//                    holding the XOR of all data nibbles of the word.
// ---------------------------------------------------------------------------
module qspi_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    qspi_serializer_if.slave  bus
);
    localparam int NIB = WORD_WIDTH / 4;
`ifdef QSPI_PARITY_EN
    localparam int FRAME_NIB = NIB + 1;
`else
    localparam int FRAME_NIB = NIB;
`endif
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NC_W  = $clog2(FRAME_NIB + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [NC_W-1:0]       nib_cnt_q, nib_cnt_d;
    logic [3:0]            data_q, data_d;
    logic                  sending_q, sending_d;

    logic                  full, empty, push, pop;
    logic [WORD_WIDTH-1:0] head;
    logic [3:0]            tail_nibble;
    logic [WORD_WIDTH+3:0] load_ext;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // word_ready depends on pre-edge state only: no push while full, even
    // when a pop happens in the same edge.
    assign push  = bus.word_valid && !full;
    assign pop   = (state_q == IDLE) && !empty && bus.qspi_ready;
    assign head  = mem[rd_ptr_q];

`ifdef QSPI_PARITY_EN
    always_comb begin
        tail_nibble = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            tail_nibble = tail_nibble ^ head[i*4 +: 4];
        end
    end
`else
    assign tail_nibble = 4'h0;
`endif

    // The first nibble goes straight to the output register, the rest of the
    // word (plus the parity nibble, if any) is left-aligned in the shifter so
    // the trailing nibble falls out naturally after the data nibbles.
    assign load_ext = {head, tail_nibble};

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        nib_cnt_d = nib_cnt_q;
        data_d    = 4'h0;
        sending_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SEND;
                    shift_d   = load_ext[WORD_WIDTH-1:0];
                    nib_cnt_d = '0;
                    data_d    = head[WORD_WIDTH-1 -: 4];
                    sending_d = 1'b1;
                end
            end
            SEND: begin
                // qspi_ready is not looked at here: a started frame completes.
                if (nib_cnt_q == NC_W'(FRAME_NIB - 1)) begin
                    state_d = IDLE;
                end else begin
                    data_d    = shift_q[WORD_WIDTH-1 -: 4];
                    shift_d   = shift_q << 4;
                    nib_cnt_d = nib_cnt_q + NC_W'(1);
                    sending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            nib_cnt_q <= '0;
            data_q    <= 4'h0;
            sending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            nib_cnt_q <= nib_cnt_d;
            data_q    <= data_d;
            sending_q <= sending_d;
        end
    end

    // Storage has no reset; clearing the count and pointers discards it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.word_data;
        end
    end

    assign bus.word_ready   = !full;
    assign bus.qspi_data    = data_q;
    assign bus.qspi_sending = sending_q;
    assign bus.fifo_count   = count_q;
    assign bus.busy         = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_qspi_serializer.sv
`timescale 1ns/1ps
module tb_qspi_serializer;
    localparam int WW    = 32;
    localparam int DEPTH = 4;
    localparam int NIB   = WW / 4;
`ifdef QSPI_PARITY_EN
    localparam int          FRAME_NIB = NIB + 1;
    localparam logic [63:0] F_1234    = 64'h1234ABCD4;
    localparam logic [63:0] F_DEAD    = 64'hDEADBEEF0;
`else
    localparam int          FRAME_NIB = NIB;
    localparam logic [63:0] F_1234    = 64'h1234ABCD;
    localparam logic [63:0] F_DEAD    = 64'hDEADBEEF;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qspi_serializer_if #(.WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)) bus ();
    qspi_serializer #(.WORD_WIDTH(WW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: word queue + nibble queue ----------
    logic [WW-1:0] m_q[$];
    logic [3:0]    m_frame[$];

`ifdef QSPI_PARITY_EN
    function automatic logic [3:0] nib_xor(input logic [WW-1:0] w);
        logic [3:0] p = 4'h0;
        for (int i = 0; i < NIB; i++) p = p ^ w[i*4 +: 4];
        return p;
    endfunction
`endif

    function automatic logic [63:0] frame_of(input logic [WW-1:0] w);
`ifdef QSPI_PARITY_EN
        return {28'h0, w, nib_xor(w)};
`else
        return {32'h0, w};
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_frame.delete();
    endtask

    task automatic model_step();
        logic          idle_pre;
        logic          push_ok;
        logic [WW-1:0] w;
        if (reset == 1'b0) begin
            model_reset();
            return;
        end
        idle_pre = (m_frame.size() == 0);
        push_ok  = bus.word_valid && (m_q.size() < DEPTH);
        if (!idle_pre) begin
            m_frame.delete(0);
        end else if (m_q.size() != 0 && bus.qspi_ready) begin
            w = m_q.pop_front();
            for (int i = NIB - 1; i >= 0; i--) m_frame.push_back(w[i*4 +: 4]);
`ifdef QSPI_PARITY_EN
            m_frame.push_back(nib_xor(w));
`endif
        end
        if (push_ok) m_q.push_back(bus.word_data);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process + frame log --------------------------
    logic [63:0] f_val[$];
    int          f_len[$];
    int          f_gap[$];
    logic [63:0] cur_val = '0;
    int          cur_len = 0;
    int          gap = 0;
    int          start_gap = 0;

    initial forever begin
        @(negedge clk);
        chk("sending", {63'h0, bus.qspi_sending}, {63'h0, m_frame.size() != 0});
        chk("data", {60'h0, bus.qspi_data}, (m_frame.size() != 0) ? {60'h0, m_frame[0]} : 64'h0);
        chk("fifo_count", {61'h0, bus.fifo_count}, 64'(m_q.size()));
        chk("word_ready", {63'h0, bus.word_ready}, {63'h0, m_q.size() < DEPTH});
        chk("busy", {63'h0, bus.busy}, {63'h0, (m_frame.size() != 0) || (m_q.size() != 0)});
        if (bus.qspi_sending) begin
            if (cur_len == 0) start_gap = gap;
            cur_val = {cur_val[59:0], bus.qspi_data};
            cur_len++;
        end else begin
            if (cur_len > 0) begin
                f_val.push_back(cur_val);
                f_len.push_back(cur_len);
                f_gap.push_back(start_gap);
                $display("frame %0d: value=%0h nibbles=%0d gap_before=%0d", f_val.size() - 1, cur_val, cur_len, start_gap);
                cur_val = '0;
                cur_len = 0;
                gap = 0;
            end
            gap++;
        end
    end

    function automatic logic [63:0] fv(input int i);
        return (i < f_val.size()) ? f_val[i] : 64'hBAD0_0000_0000_0000;
    endfunction
    function automatic int fl(input int i);
        return (i < f_len.size()) ? f_len[i] : -1;
    endfunction
    function automatic int fg(input int i);
        return (i < f_gap.size()) ? f_gap[i] : -1;
    endfunction

    task automatic clear_log();
        f_val.delete();
        f_len.delete();
        f_gap.delete();
        cur_val = '0;
        cur_len = 0;
        gap = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", budget);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ---------------------------------------------
    logic [WW-1:0] w[5];
    logic [WW-1:0] wa, wb;

    initial begin
        bus.word_data  = '0;
        bus.word_valid = 1'b0;
        bus.qspi_ready = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state after idle cycles
        repeat (5) @(negedge clk);
        chk("rst_sending", {63'h0, bus.qspi_sending}, 64'h0);
        chk("rst_data", {60'h0, bus.qspi_data}, 64'h0);
        chk("rst_word_ready", {63'h0, bus.word_ready}, 64'h1);
        chk("rst_fifo_count", {61'h0, bus.fifo_count}, 64'h0);
        chk("rst_busy", {63'h0, bus.busy}, 64'h0);
        tick();

        // Single frame and latency
        clear_log();
        bus.qspi_ready = 1'b1;
        bus.word_data  = 32'h1234ABCD;
        bus.word_valid = 1'b1;
        tick();
        bus.word_valid = 1'b0;
        chk("lat_push_edge_sending", {63'h0, bus.qspi_sending}, 64'h0);
        chk("lat_push_edge_count", {61'h0, bus.fifo_count}, 64'h1);
        tick();
        chk("lat_first_sending", {63'h0, bus.qspi_sending}, 64'h1);
        chk("lat_first_nibble", {60'h0, bus.qspi_data}, 64'h1);
        wait_idle(50);
        chk("single_frames", 64'(f_val.size()), 64'h1);
        chk("single_value", fv(0), F_1234);
        chk("single_len", 64'(fl(0)), 64'(FRAME_NIB));

        // Back-to-back frames
        clear_log();
        bus.word_valid = 1'b1;
        bus.word_data  = 32'h1234ABCD;
        tick();
        bus.word_data  = 32'hDEADBEEF;
        tick();
        bus.word_valid = 1'b0;
        wait_idle(60);
        chk("b2b_frames", 64'(f_val.size()), 64'h2);
        chk("b2b_value0", fv(0), F_1234);
        chk("b2b_value1", fv(1), F_DEAD);
        chk("b2b_len1", 64'(fl(1)), 64'(FRAME_NIB));
        chk("b2b_gap", 64'(fg(1)), 64'h1);

        // Fill while far end not ready; 5th word dropped
        clear_log();
        bus.qspi_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = $urandom;
            bus.word_valid = 1'b1;
            bus.word_data  = w[i];
            tick();
        end
        bus.word_valid = 1'b0;
        chk("full_count", {61'h0, bus.fifo_count}, 64'h4);
        chk("full_ready", {63'h0, bus.word_ready}, 64'h0);
        chk("full_no_frames", 64'(f_val.size()), 64'h0);
        bus.qspi_ready = 1'b1;
        wait_idle(100);
        chk("drain_frames", 64'(f_val.size()), 64'h4);
        for (int i = 0; i < 4; i++) chk($sformatf("drain_value%0d", i), fv(i), frame_of(w[i]));

        // Drop qspi_ready mid-frame
        clear_log();
        bus.qspi_ready = 1'b0;
        wa = $urandom;
        wb = $urandom;
        bus.word_valid = 1'b1;
        bus.word_data  = wa;
        tick();
        bus.word_data  = wb;
        tick();
        bus.word_valid = 1'b0;
        bus.qspi_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!bus.qspi_sending && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        tick();
        bus.qspi_ready = 1'b0;
        repeat (20) tick();
        chk("hold_frames", 64'(f_val.size()), 64'h1);
        chk("hold_value", fv(0), frame_of(wa));
        chk("hold_count", {61'h0, bus.fifo_count}, 64'h1);
        chk("hold_sending", {63'h0, bus.qspi_sending}, 64'h0);

        // Reset during 3rd nibble of the next frame
        bus.qspi_ready = 1'b1;
        bus.word_valid = 1'b1;
        bus.word_data  = $urandom;
        tick();
        bus.word_data  = $urandom;
        tick();
        bus.word_valid = 1'b0;
        tick();
        #1;
        chk("mid_nib3_sending", {63'h0, bus.qspi_sending}, 64'h1);
        chk("mid_nib3_data", {60'h0, bus.qspi_data}, {60'h0, wb[23:20]});
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_sending", {63'h0, bus.qspi_sending}, 64'h0);
        chk("abort_count", {61'h0, bus.fifo_count}, 64'h0);
        chk("abort_busy", {63'h0, bus.busy}, 64'h0);
        tick();
        reset = 1'b1;
        clear_log();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bus.word_valid = 1'($urandom_range(0, 1));
            bus.word_data  = $urandom;
            bus.qspi_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
        end
        reset = 1'b1;
        bus.word_valid = 1'b0;
        bus.qspi_ready = 1'b1;
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
